// File: rtl/arch_trace_pkg.sv
// Shared types and constants for the architectural step trace path.
package arch_trace_pkg;
    localparam int XLEN_DEFAULT = 64;
    localparam int ILEN_DEFAULT = 32;
    localparam int DROP_CNT_W   = 16;

    // One retired instruction as seen on ArchStepBB.
    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [ILEN_DEFAULT-1:0] inst;
        logic [XLEN_DEFAULT-1:0] data;
    } arch_step_t;
endpackage

// File: rtl/arch_step_fifo.sv
// Dual-write, single-read circular buffer of retirement entries.
// When empty, the read port shows write slot 0, so an entry written and
// read in the same cycle passes straight through and is never stored
// as live data.
module arch_step_fifo
    import arch_trace_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = arch_step_t,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [1:0]    wr_cnt,
    input  entry_t        wr_data0,
    input  entry_t        wr_data1,
    input  logic          rd_en,
    output entry_t        rd_data,
    output logic [CW-1:0] count
);
    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage: no reset needed, the pointers define which slots are live.
    always_ff @(posedge clock) begin
        if (wr_cnt != 2'd0) mem[wr_ptr] <= wr_data0;
        if (wr_cnt == 2'd2) mem[wr_ptr + AW'(1)] <= wr_data1;
    end

    // Pointers wrap naturally at the power-of-two depth; count spans 0..DEPTH.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_cnt);
            rd_ptr <= rd_ptr + AW'(rd_en);
            count  <= count + CW'(wr_cnt) - CW'(rd_en);
        end
    end

    assign rd_data = (count == '0) ? wr_data0 : mem[rd_ptr];
endmodule

// File: rtl/arch_step_serializer.sv
// Serializes dual-lane commits into a single-lane architectural step trace.
// Lanes are compacted, admitted against the start-of-cycle free space
// (oldest first), and drained one per cycle unless held.
module arch_step_serializer
    import arch_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int ILEN  = ILEN_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  c0_valid,
    input  logic [XLEN-1:0]       c0_pc,
    input  logic [ILEN-1:0]       c0_inst,
    input  logic [XLEN-1:0]       c0_data,
    input  logic                  c1_valid,
    input  logic [XLEN-1:0]       c1_pc,
    input  logic [ILEN-1:0]       c1_inst,
    input  logic [XLEN-1:0]       c1_data,
    input  logic                  hold,
    output logic                  in_ready,
    output logic                  step_valid,
    output logic [XLEN-1:0]       step_pc,
    output logic [ILEN-1:0]       step_inst,
    output logic [XLEN-1:0]       step_data,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic [63:0]           step_count
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] data;
    } step_t;

    step_t           ent0, ent1, head, step_q;
    logic [CW-1:0]   count, free;
    logic [1:0]      n_valid, n_acc, n_drop;
    logic            rd_en;
    logic [DROP_CNT_W:0] drop_sum;

    // Compaction: a lone lane-1 commit moves into slot 0; admission is
    // bounded by free space from the registered count, lane 0 first.
    always_comb begin
        ent0     = c0_valid ? step_t'{c0_pc, c0_inst, c0_data}
                            : step_t'{c1_pc, c1_inst, c1_data};
        ent1     = step_t'{c1_pc, c1_inst, c1_data};
        free     = CW'(DEPTH) - count;
        n_valid  = {1'b0, c0_valid} + {1'b0, c1_valid};
        n_acc    = (CW'(n_valid) > free) ? free[1:0] : n_valid;
        n_drop   = n_valid - n_acc;
        rd_en    = !hold && ((count != '0) || (n_acc != 2'd0));
        drop_sum = {1'b0, drop_count} + (DROP_CNT_W+1)'(n_drop);
    end

    arch_step_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (step_t)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .wr_cnt   (n_acc),
        .wr_data0 (ent0),
        .wr_data1 (ent1),
        .rd_en    (rd_en),
        .rd_data  (head),
        .count    (count)
    );

    assign in_ready = (free >= CW'(2));

    // Output stage and counters: step data holds its last value when idle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            step_valid <= 1'b0;
            step_q     <= '0;
            step_count <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            step_valid <= rd_en;
            if (rd_en) begin
                step_q     <= head;
                step_count <= step_count + 64'd1;
            end
            if (n_drop != 2'd0) begin
                overflow   <= 1'b1;
                drop_count <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
            end
        end
    end

    assign step_pc   = step_q.pc;
    assign step_inst = step_q.inst;
    assign step_data = step_q.data;
endmodule

// File: tb/tb_arch_step_serializer.sv
// Directed bench for arch_step_serializer (DEPTH=8, XLEN=64, ILEN=32).
module tb_arch_step_serializer;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        c0_valid = 1'b0, c1_valid = 1'b0, hold = 1'b0;
    logic [63:0] c0_pc = '0, c0_data = '0, c1_pc = '0, c1_data = '0;
    logic [31:0] c0_inst = '0, c1_inst = '0;
    logic        in_ready, step_valid, overflow;
    logic [63:0] step_pc, step_data, step_count;
    logic [31:0] step_inst;
    logic [15:0] drop_count;

    int n_cmp  = 0;
    int n_fail = 0;

    arch_step_serializer #(.DEPTH(8), .XLEN(64), .ILEN(32)) dut (
        .clock(clock), .reset(reset),
        .c0_valid(c0_valid), .c0_pc(c0_pc), .c0_inst(c0_inst), .c0_data(c0_data),
        .c1_valid(c1_valid), .c1_pc(c1_pc), .c1_inst(c1_inst), .c1_data(c1_data),
        .hold(hold), .in_ready(in_ready), .step_valid(step_valid),
        .step_pc(step_pc), .step_inst(step_inst), .step_data(step_data),
        .overflow(overflow), .drop_count(drop_count), .step_count(step_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] f_inst(input logic [63:0] pc);
        return {pc[15:0], 16'h0013};
    endfunction

    function automatic logic [63:0] f_data(input logic [63:0] pc);
        return {48'h0, pc[15:0]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [63:0] p0,
                         input logic v1, input logic [63:0] p1);
        c0_valid = v0; c0_pc = p0; c0_inst = f_inst(p0); c0_data = f_data(p0);
        c1_valid = v1; c1_pc = p1; c1_inst = f_inst(p1); c1_data = f_data(p1);
    endtask

    task automatic idle();
        drive(1'b0, 64'h0, 1'b0, 64'h0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        hold = 1'b0;
        tick(); tick();
        reset = 1'b1;
        n_cmp++; if (step_valid !== 1'b0) begin n_fail++; $display("FAIL reset_step_valid got %0b want 0", step_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        n_cmp++; if (step_count !== 64'd0) begin n_fail++; $display("FAIL reset_step_count got %0d want 0", step_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        n_cmp++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drop_count got %0d want 0", drop_count); end
        n_cmp++; if ({step_pc, step_inst, step_data} !== 160'd0) begin n_fail++; $display("FAIL reset_step_fields got %h/%h/%h want 0", step_pc, step_inst, step_data); end
        tick();
        n_cmp++; if (step_valid !== 1'b0) begin n_fail++; $display("FAIL idle_step_valid got %0b want 0", step_valid); end
    endtask

    task automatic test_single();
        drive(1'b1, 64'h80000000, 1'b0, 64'h0);
        tick();
        idle();
        n_cmp++; if (step_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b want 1", step_valid); end
        n_cmp++; if ({step_pc, step_inst, step_data} !== {64'h80000000, 32'h00000013, 64'h0})
            begin n_fail++; $display("FAIL single_fields got %h/%h/%h want 80000000/00000013/0", step_pc, step_inst, step_data); end
        n_cmp++; if (step_count !== 64'd1) begin n_fail++; $display("FAIL single_step_count got %0d want 1", step_count); end
        tick();
        n_cmp++; if (step_valid !== 1'b0) begin n_fail++; $display("FAIL single_after_valid got %0b want 0", step_valid); end
        n_cmp++; if (step_pc !== 64'h80000000) begin n_fail++; $display("FAIL single_hold_pc got %h want 80000000", step_pc); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ep;
        for (int j = 0; j < 8; j++) begin
            if (j < 4) drive(1'b1, 64'h100 + 64'(8 * j), 1'b1, 64'h104 + 64'(8 * j));
            else idle();
            tick();
            ep = 64'h100 + 64'(4 * j);
            n_cmp++; if ({step_valid, step_pc, step_inst, step_data} !== {1'b1, ep, f_inst(ep), f_data(ep)})
                begin n_fail++; $display("FAIL b2b_step%0d got v=%0b pc=%h inst=%h data=%h want pc=%h", j, step_valid, step_pc, step_inst, step_data, ep); end
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready%0d got %0b want 1", j, in_ready); end
        end
        idle();
        tick();
        n_cmp++; if (step_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got %0b want 0", step_valid); end
        n_cmp++; if (step_count !== 64'd9) begin n_fail++; $display("FAIL b2b_step_count got %0d want 9", step_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow got %0b want 0", overflow); end
    endtask

    task automatic test_hold_overflow();
        logic [63:0] ep;
        logic        exp_rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [15:0] exp_drop [5] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd2};
        hold = 1'b1;
        for (int j = 0; j < 5; j++) begin
            drive(1'b1, 64'h200 + 64'(8 * j), 1'b1, 64'h204 + 64'(8 * j));
            tick();
            n_cmp++; if (step_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid%0d got %0b want 0", j, step_valid); end
            n_cmp++; if (in_ready !== exp_rdy[j]) begin n_fail++; $display("FAIL hold_in_ready%0d got %0b want %0b", j, in_ready, exp_rdy[j]); end
            n_cmp++; if (drop_count !== exp_drop[j]) begin n_fail++; $display("FAIL hold_drop%0d got %0d want %0d", j, drop_count, exp_drop[j]); end
        end
        idle();
        tick();
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL hold_overflow got %0b want 1", overflow); end
        n_cmp++; if (step_count !== 64'd9) begin n_fail++; $display("FAIL hold_step_count got %0d want 9", step_count); end
        hold = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            ep = 64'h200 + 64'(4 * k);
            n_cmp++; if ({step_valid, step_pc, step_inst, step_data} !== {1'b1, ep, f_inst(ep), f_data(ep)})
                begin n_fail++; $display("FAIL release_step%0d got v=%0b pc=%h want pc=%h", k, step_valid, step_pc, ep); end
            n_cmp++; if (in_ready !== (k >= 1)) begin n_fail++; $display("FAIL release_in_ready%0d got %0b want %0b", k, in_ready, k >= 1); end
        end
        tick();
        n_cmp++; if (step_valid !== 1'b0) begin n_fail++; $display("FAIL release_done got %0b want 0", step_valid); end
        n_cmp++; if (step_count !== 64'd17) begin n_fail++; $display("FAIL release_step_count got %0d want 17", step_count); end
        n_cmp++; if (drop_count !== 16'd2) begin n_fail++; $display("FAIL release_drop got %0d want 2", drop_count); end
    endtask

    task automatic test_c1_only();
        drive(1'b0, 64'h0, 1'b1, 64'h1000);
        tick();
        idle();
        n_cmp++; if ({step_valid, step_pc, step_inst, step_data} !== {1'b1, 64'h1000, 32'h10000013, 64'h1000})
            begin n_fail++; $display("FAIL c1_only_step got v=%0b pc=%h inst=%h data=%h want pc=1000", step_valid, step_pc, step_inst, step_data); end
        tick();
        n_cmp++; if (step_valid !== 1'b0) begin n_fail++; $display("FAIL c1_only_single got %0b want 0", step_valid); end
        n_cmp++; if (drop_count !== 16'd2) begin n_fail++; $display("FAIL c1_only_drop got %0d want 2", drop_count); end
        n_cmp++; if (step_count !== 64'd18) begin n_fail++; $display("FAIL c1_only_step_count got %0d want 18", step_count); end
    endtask

    task automatic test_reset_mid_drain();
        hold = 1'b1;
        drive(1'b1, 64'h500, 1'b1, 64'h504); tick();
        drive(1'b1, 64'h508, 1'b1, 64'h50c); tick();
        drive(1'b1, 64'h510, 1'b0, 64'h0);   tick();
        idle();
        hold = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_cmp++; if (step_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %0b want 0", step_valid); end
        n_cmp++; if ({step_count, drop_count, overflow} !== {64'd0, 16'd0, 1'b0})
            begin n_fail++; $display("FAIL rstmid_counters got sc=%0d dc=%0d ov=%0b want 0", step_count, drop_count, overflow); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got %0b want 1", in_ready); end
        n_cmp++; if (step_pc !== 64'd0) begin n_fail++; $display("FAIL rstmid_pc got %h want 0", step_pc); end
        for (int j = 0; j < 3; j++) begin
            tick();
            n_cmp++; if (step_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet%0d got %0b want 0", j, step_valid); end
        end
    endtask

    task automatic test_partial_drop();
        logic [63:0] ep;
        hold = 1'b1;
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 64'h300 + 64'(8 * j), 1'b1, 64'h304 + 64'(8 * j));
            tick();
        end
        drive(1'b1, 64'h318, 1'b0, 64'h0); tick();
        drive(1'b1, 64'h31c, 1'b1, 64'h320); tick();
        idle();
        n_cmp++; if ({drop_count, overflow} !== {16'd1, 1'b1})
            begin n_fail++; $display("FAIL partial_drop got dc=%0d ov=%0b want 1/1", drop_count, overflow); end
        hold = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            ep = 64'h300 + 64'(4 * k);
            n_cmp++; if ({step_valid, step_pc} !== {1'b1, ep})
                begin n_fail++; $display("FAIL partial_step%0d got v=%0b pc=%h want pc=%h", k, step_valid, step_pc, ep); end
        end
        tick();
        n_cmp++; if (step_valid !== 1'b0) begin n_fail++; $display("FAIL partial_done got %0b want 0", step_valid); end
        n_cmp++; if (step_count !== 64'd8) begin n_fail++; $display("FAIL partial_step_count got %0d want 8", step_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_overflow();
        test_c1_only();
        test_reset_mid_drain();
        test_partial_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
